// File: rtl/ahb_ram_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single RAM slave.
// Keeps one address phase pending per master so a losing master can be released from HREADY early.
module ahb_ram_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [31:0] M0_HADDR,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HRESP,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [31:0] M1_HADDR,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HRESP,
    output logic        S_HSEL,
    output logic [1:0]  S_HTRANS,
    output logic        S_HWRITE,
    output logic [2:0]  S_HSIZE,
    output logic [2:0]  S_HBURST,
    output logic [3:0]  S_HPROT,
    output logic        S_HMASTLOCK,
    output logic [31:0] S_HADDR,
    output logic [31:0] S_HWDATA,
    output logic        S_HREADY,
    input  logic        S_HREADYOUT,
    input  logic [31:0] S_HRDATA,
    input  logic        S_HRESP
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DATA = 2'd2
    } mstate_t;

    logic        m_active [2];
    logic        m_write  [2];
    logic [2:0]  m_size   [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_wdata  [2];

    mstate_t     state     [2];
    mstate_t     state_nxt [2];
    logic [31:0] buf_addr  [2];
    logic        buf_write [2];
    logic [2:0]  buf_size  [2];

    logic [1:0]  hready;
    logic [1:0]  live;
    logic [1:0]  req;
    logic [1:0]  capture;
    logic        dphase_active;
    logic        dphase_owner;
    logic        last_granted;
    logic        arb_en;
    logic        grant_valid;
    logic        grant_idx;
    logic [31:0] sel_addr;
    logic        sel_write;
    logic [2:0]  sel_size;
    logic        unused_htrans_lsb;

    // SEQ behaves like NONSEQ and BUSY like IDLE, so only HTRANS[1] matters.
    assign m_active[0] = M0_HTRANS[1];
    assign m_active[1] = M1_HTRANS[1];
    assign unused_htrans_lsb = M0_HTRANS[0] ^ M1_HTRANS[0];
    assign m_write[0]  = M0_HWRITE;
    assign m_write[1]  = M1_HWRITE;
    assign m_size[0]   = M0_HSIZE;
    assign m_size[1]   = M1_HSIZE;
    assign m_addr[0]   = M0_HADDR;
    assign m_addr[1]   = M1_HADDR;
    assign m_wdata[0]  = M0_HWDATA;
    assign m_wdata[1]  = M1_HWDATA;

    always_comb begin
        hready = '0;
        live   = '0;
        req    = '0;
        for (int n = 0; n < 2; n++) begin
            hready[n] = (state[n] == ST_IDLE) ||
                        ((state[n] == ST_DATA) && (dphase_owner == 1'(n)) && S_HREADYOUT);
            live[n]   = m_active[n] & hready[n];
            req[n]    = (state[n] == ST_PEND) | live[n];
        end
    end

    // Reset gating keeps a live request seen during reset from reaching the slave.
    always_comb begin
        arb_en      = S_HREADYOUT & RES_N;
        grant_valid = arb_en & (|req);
        if (&req) begin
            grant_idx = (ROUND_ROBIN != 0) ? ~last_granted : 1'b0;
        end else begin
            grant_idx = ~req[0];
        end
        if (state[grant_idx] == ST_PEND) begin
            sel_addr  = buf_addr[grant_idx];
            sel_write = buf_write[grant_idx];
            sel_size  = buf_size[grant_idx];
        end else begin
            sel_addr  = m_addr[grant_idx];
            sel_write = m_write[grant_idx];
            sel_size  = m_size[grant_idx];
        end
    end

    always_comb begin
        capture = '0;
        for (int n = 0; n < 2; n++) begin
            state_nxt[n] = state[n];
            if (grant_valid && (grant_idx == 1'(n))) begin
                state_nxt[n] = ST_DATA;
            end else if (live[n]) begin
                state_nxt[n] = ST_PEND;
                capture[n]   = 1'b1;
            end else if ((state[n] == ST_DATA) && S_HREADYOUT) begin
                state_nxt[n] = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            for (int n = 0; n < 2; n++) begin
                state[n]     <= ST_IDLE;
                buf_addr[n]  <= '0;
                buf_write[n] <= 1'b0;
                buf_size[n]  <= '0;
            end
            dphase_active <= 1'b0;
            dphase_owner  <= 1'b0;
            last_granted  <= 1'b1;
        end else begin
            for (int n = 0; n < 2; n++) begin
                state[n] <= state_nxt[n];
                if (capture[n]) begin
                    buf_addr[n]  <= m_addr[n];
                    buf_write[n] <= m_write[n];
                    buf_size[n]  <= m_size[n];
                end
            end
            if (grant_valid) begin
                last_granted <= grant_idx;
            end
            if (S_HREADYOUT) begin
                dphase_active <= grant_valid;
                if (grant_valid) begin
                    dphase_owner <= grant_idx;
                end
            end
        end
    end

    assign S_HSEL      = grant_valid;
    assign S_HTRANS    = grant_valid ? 2'b10 : 2'b00;
    assign S_HADDR     = grant_valid ? sel_addr : '0;
    assign S_HWRITE    = grant_valid & sel_write;
    assign S_HSIZE     = grant_valid ? sel_size : '0;
    assign S_HBURST    = 3'b000;
    assign S_HPROT     = 4'b0011;
    assign S_HMASTLOCK = 1'b0;
    assign S_HREADY    = S_HREADYOUT;
    assign S_HWDATA    = dphase_active ? m_wdata[dphase_owner] : '0;

    assign M0_HREADY = hready[0];
    assign M1_HREADY = hready[1];
    assign M0_HRDATA = RES_N ? S_HRDATA : '0;
    assign M1_HRDATA = RES_N ? S_HRDATA : '0;
    assign M0_HRESP  = dphase_active & ~dphase_owner & S_HRESP;
    assign M1_HRESP  = dphase_active &  dphase_owner & S_HRESP;

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Directed bench for ahb_ram_arbiter: a round-robin instance on a RAM model with
// programmable wait states, plus a fixed-priority instance on an always-ready slave.
module tb_ahb_ram_arbiter;

    logic        CLK;
    logic        RES_N;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
    logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
    logic [31:0] M0_HRDATA, M1_HRDATA;
    logic        S_HSEL, S_HWRITE, S_HMASTLOCK, S_HREADY, S_HREADYOUT, S_HRESP;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE, S_HBURST;
    logic [3:0]  S_HPROT;
    logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;

    logic [1:0]  fp_m0_htrans, fp_m1_htrans, fp_s_htrans;
    logic [31:0] fp_m0_haddr, fp_m1_haddr, fp_m0_hrdata, fp_m1_hrdata;
    logic        fp_m0_hready, fp_m1_hready, fp_m0_hresp, fp_m1_hresp;
    logic        fp_s_hsel, fp_s_hwrite, fp_s_hmastlock, fp_s_hready;
    logic [2:0]  fp_s_hsize, fp_s_hburst;
    logic [3:0]  fp_s_hprot;
    logic [31:0] fp_s_haddr, fp_s_hwdata;
    logic        fp_s_hreadyout;
    logic [31:0] fp_s_hrdata;
    logic        fp_s_hresp;

    int          n_compared;
    int          n_mismatched;
    int          wait_states;
    logic        slave_err;
    logic [31:0] mem [256];
    logic        sl_valid, sl_write;
    logic [31:0] sl_addr;
    int          sl_wait;

    ahb_ram_arbiter #(.ROUND_ROBIN(1)) dut (
        .CLK(CLK), .RES_N(RES_N),
        .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE), .M0_HADDR(M0_HADDR),
        .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA), .M0_HRESP(M0_HRESP),
        .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE), .M1_HADDR(M1_HADDR),
        .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA), .M1_HRESP(M1_HRESP),
        .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
        .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HMASTLOCK(S_HMASTLOCK), .S_HADDR(S_HADDR),
        .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT),
        .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP)
    );

    ahb_ram_arbiter #(.ROUND_ROBIN(0)) dut_fp (
        .CLK(CLK), .RES_N(RES_N),
        .M0_HTRANS(fp_m0_htrans), .M0_HWRITE(1'b0), .M0_HSIZE(3'b010), .M0_HADDR(fp_m0_haddr),
        .M0_HWDATA(32'h0), .M0_HREADY(fp_m0_hready), .M0_HRDATA(fp_m0_hrdata), .M0_HRESP(fp_m0_hresp),
        .M1_HTRANS(fp_m1_htrans), .M1_HWRITE(1'b0), .M1_HSIZE(3'b010), .M1_HADDR(fp_m1_haddr),
        .M1_HWDATA(32'h0), .M1_HREADY(fp_m1_hready), .M1_HRDATA(fp_m1_hrdata), .M1_HRESP(fp_m1_hresp),
        .S_HSEL(fp_s_hsel), .S_HTRANS(fp_s_htrans), .S_HWRITE(fp_s_hwrite), .S_HSIZE(fp_s_hsize),
        .S_HBURST(fp_s_hburst), .S_HPROT(fp_s_hprot), .S_HMASTLOCK(fp_s_hmastlock), .S_HADDR(fp_s_haddr),
        .S_HWDATA(fp_s_hwdata), .S_HREADY(fp_s_hready), .S_HREADYOUT(fp_s_hreadyout),
        .S_HRDATA(fp_s_hrdata), .S_HRESP(fp_s_hresp)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign fp_s_hreadyout = 1'b1;
    assign fp_s_hrdata    = 32'h0;
    assign fp_s_hresp     = 1'b0;

    // RAM slave model: captures an address phase, stalls wait_states cycles, then completes.
    assign S_HREADYOUT = !(sl_valid && (sl_wait != 0));
    assign S_HRDATA    = (sl_valid && !sl_write) ? mem[sl_addr[9:2]] : 32'h0;
    assign S_HRESP     = slave_err;

    always @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            sl_valid  <= 1'b0;
            sl_write  <= 1'b0;
            sl_addr   <= 32'h0;
            sl_wait   <= 0;
            mem[8'h40] <= 32'hA5A5_0100;
        end else if (S_HREADYOUT) begin
            if (sl_valid && sl_write) mem[sl_addr[9:2]] <= S_HWDATA;
            if (S_HSEL && S_HTRANS[1] && S_HREADY) begin
                sl_valid <= 1'b1;
                sl_write <= S_HWRITE;
                sl_addr  <= S_HADDR;
                sl_wait  <= wait_states;
            end else begin
                sl_valid <= 1'b0;
            end
        end else begin
            sl_wait <= sl_wait - 1;
        end
    end

    task automatic drive_idle;
        M0_HTRANS = 2'b00; M0_HWRITE = 1'b0; M0_HSIZE = 3'b010; M0_HADDR = 32'h0; M0_HWDATA = 32'h0;
        M1_HTRANS = 2'b00; M1_HWRITE = 1'b0; M1_HSIZE = 3'b010; M1_HADDR = 32'h0; M1_HWDATA = 32'h0;
        fp_m0_htrans = 2'b00; fp_m0_haddr = 32'h0; fp_m1_htrans = 2'b00; fp_m1_haddr = 32'h0;
        slave_err = 1'b0;
    endtask

    task automatic do_reset;
        drive_idle();
        wait_states = 0;
        RES_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RES_N = 1'b1;
    endtask

    task automatic test_reset;
        drive_idle();
        wait_states = 0;
        RES_N = 1'b0;
        M0_HTRANS = 2'b10;
        M0_HADDR  = 32'h100;
        M1_HWDATA = 32'h5555_AAAA;
        #3;
        n_compared++; if (M0_HREADY !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_m0_hready: got %b want 1", M0_HREADY); end
        n_compared++; if (M1_HREADY !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_m1_hready: got %b want 1", M1_HREADY); end
        n_compared++; if (S_HTRANS !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_htrans: got %b want 00", S_HTRANS); end
        n_compared++; if (S_HSEL !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_hsel: got %b want 0", S_HSEL); end
        n_compared++; if (S_HWDATA !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_hwdata: got %h want 0", S_HWDATA); end
        n_compared++; if (M0_HRDATA !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_hrdata: got %h want 0", M0_HRDATA); end
        n_compared++; if (M1_HRESP !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_hresp: got %b want 0", M1_HRESP); end
        n_compared++; if (S_HPROT !== 4'b0011) begin n_mismatched++; $display("[TB] FAIL hprot: got %b want 0011", S_HPROT); end
        n_compared++; if ({S_HBURST, S_HMASTLOCK} !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL hburst_lock: got %b want 0000", {S_HBURST, S_HMASTLOCK}); end
        do_reset();
    endtask

    task automatic test_single_read;
        do_reset();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h100;
        @(negedge CLK);
        n_compared++; if (S_HADDR !== 32'h100) begin n_mismatched++; $display("[TB] FAIL single_haddr: got %h want 100", S_HADDR); end
        n_compared++; if (S_HTRANS !== 2'b10) begin n_mismatched++; $display("[TB] FAIL single_htrans: got %b want 10", S_HTRANS); end
        n_compared++; if (M0_HREADY !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_hready_a: got %b want 1", M0_HREADY); end
        @(posedge CLK); #1;
        M0_HTRANS = 2'b00;
        @(negedge CLK);
        n_compared++; if (M0_HRDATA !== 32'hA5A5_0100) begin n_mismatched++; $display("[TB] FAIL single_hrdata: got %h want a5a50100", M0_HRDATA); end
        n_compared++; if (M0_HREADY !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_hready_d: got %b want 1", M0_HREADY); end
        @(posedge CLK); #1;
    endtask

    task automatic test_contention;
        do_reset();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h200;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h300; M1_HWRITE = 1'b1; M1_HWDATA = 32'h1234_5678;
        @(negedge CLK);
        n_compared++; if (S_HADDR !== 32'h200) begin n_mismatched++; $display("[TB] FAIL contend_first: got %h want 200", S_HADDR); end
        @(posedge CLK); #1;
        M0_HTRANS = 2'b00; M1_HTRANS = 2'b00; M1_HWRITE = 1'b0;
        @(negedge CLK);
        n_compared++; if (M1_HREADY !== 1'b0) begin n_mismatched++; $display("[TB] FAIL contend_m1_stall: got %b want 0", M1_HREADY); end
        n_compared++; if (S_HADDR !== 32'h300) begin n_mismatched++; $display("[TB] FAIL contend_second: got %h want 300", S_HADDR); end
        n_compared++; if (S_HWRITE !== 1'b1) begin n_mismatched++; $display("[TB] FAIL contend_hwrite: got %b want 1", S_HWRITE); end
        @(posedge CLK); #1;
        @(negedge CLK);
        n_compared++; if (M1_HREADY !== 1'b1) begin n_mismatched++; $display("[TB] FAIL contend_m1_done: got %b want 1", M1_HREADY); end
        n_compared++; if (S_HWDATA !== 32'h1234_5678) begin n_mismatched++; $display("[TB] FAIL contend_hwdata: got %h want 12345678", S_HWDATA); end
        @(posedge CLK); #1;
    endtask

    // Both arbiter instances see their own pair of masters streaming four reads each.
    task automatic test_arbitration_order;
        logic [31:0] exp_rr [8] = '{32'h000, 32'h100, 32'h004, 32'h104, 32'h008, 32'h108, 32'h00C, 32'h10C};
        logic [31:0] exp_fp [8] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h100, 32'h104, 32'h108, 32'h10C};
        int i0 = 0, i1 = 0, f0 = 0, f1 = 0, g_rr = 0, g_fp = 0;
        logic a0, a1, b0, b1;
        do_reset();
        for (int cyc = 0; cyc < 14; cyc++) begin
            M0_HTRANS = (i0 < 4) ? 2'b10 : 2'b00; M0_HADDR = 32'(i0 * 4);
            M1_HTRANS = (i1 < 4) ? 2'b10 : 2'b00; M1_HADDR = 32'h100 + 32'(i1 * 4);
            fp_m0_htrans = (f0 < 4) ? 2'b10 : 2'b00; fp_m0_haddr = 32'(f0 * 4);
            fp_m1_htrans = (f1 < 4) ? 2'b10 : 2'b00; fp_m1_haddr = 32'h100 + 32'(f1 * 4);
            @(negedge CLK);
            if (S_HTRANS == 2'b10) begin
                if (g_rr < 8) begin
                    n_compared++; if (S_HADDR !== exp_rr[g_rr]) begin n_mismatched++; $display("[TB] FAIL rr_grant%0d: got %h want %h", g_rr, S_HADDR, exp_rr[g_rr]); end
                end
                g_rr++;
            end
            if (fp_s_htrans == 2'b10) begin
                if (g_fp < 8) begin
                    n_compared++; if (fp_s_haddr !== exp_fp[g_fp]) begin n_mismatched++; $display("[TB] FAIL fp_grant%0d: got %h want %h", g_fp, fp_s_haddr, exp_fp[g_fp]); end
                end
                g_fp++;
            end
            a0 = (i0 < 4) && M0_HREADY;    a1 = (i1 < 4) && M1_HREADY;
            b0 = (f0 < 4) && fp_m0_hready; b1 = (f1 < 4) && fp_m1_hready;
            @(posedge CLK); #1;
            if (a0) i0++;
            if (a1) i1++;
            if (b0) f0++;
            if (b1) f1++;
        end
        n_compared++; if (g_rr !== 8) begin n_mismatched++; $display("[TB] FAIL rr_grant_count: got %0d want 8", g_rr); end
        n_compared++; if (g_fp !== 8) begin n_mismatched++; $display("[TB] FAIL fp_grant_count: got %0d want 8", g_fp); end
        drive_idle();
    endtask

    task automatic test_wait_states;
        int k;
        do_reset();
        wait_states = 3;
        M0_HTRANS = 2'b10; M0_HADDR = 32'h80;
        @(negedge CLK);
        n_compared++; if (S_HADDR !== 32'h80) begin n_mismatched++; $display("[TB] FAIL ws_m0_addr: got %h want 80", S_HADDR); end
        @(posedge CLK); #1;
        M0_HTRANS = 2'b00;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h84;
        @(negedge CLK);
        n_compared++; if (S_HTRANS !== 2'b00) begin n_mismatched++; $display("[TB] FAIL ws_htrans_stall: got %b want 00", S_HTRANS); end
        n_compared++; if (M1_HREADY !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ws_m1_accept: got %b want 1", M1_HREADY); end
        @(posedge CLK); #1;
        M1_HTRANS = 2'b00;
        for (k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (S_HREADYOUT) break;
            n_compared++; if (S_HTRANS !== 2'b00) begin n_mismatched++; $display("[TB] FAIL ws_htrans_wait%0d: got %b want 00", k, S_HTRANS); end
            n_compared++; if (M1_HREADY !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ws_m1_pend%0d: got %b want 0", k, M1_HREADY); end
            @(posedge CLK); #1;
        end
        n_compared++; if (k !== 2) begin n_mismatched++; $display("[TB] FAIL ws_wait_cycles: got %0d want 2", k); end
        n_compared++; if (S_HTRANS !== 2'b10) begin n_mismatched++; $display("[TB] FAIL ws_m1_issue: got %b want 10", S_HTRANS); end
        n_compared++; if (S_HADDR !== 32'h84) begin n_mismatched++; $display("[TB] FAIL ws_m1_addr: got %h want 84", S_HADDR); end
        n_compared++; if (M0_HREADY !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ws_m0_done: got %b want 1", M0_HREADY); end
        @(posedge CLK); #1;
        repeat (5) @(posedge CLK);
        #1;
    endtask

    task automatic test_back_to_back;
        do_reset();
        M1_HTRANS = 2'b10; M1_HADDR = 32'h40; M1_HWRITE = 1'b1; M1_HWDATA = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        M1_HTRANS = 2'b00; M1_HWRITE = 1'b0;
        M0_HTRANS = 2'b10; M0_HADDR = 32'h40;
        @(negedge CLK);
        n_compared++; if (S_HWDATA !== 32'hDEAD_BEEF) begin n_mismatched++; $display("[TB] FAIL b2b_hwdata: got %h want deadbeef", S_HWDATA); end
        n_compared++; if (S_HADDR !== 32'h40) begin n_mismatched++; $display("[TB] FAIL b2b_m0_addr: got %h want 40", S_HADDR); end
        @(posedge CLK); #1;
        M0_HTRANS = 2'b00;
        @(negedge CLK);
        n_compared++; if (M0_HRDATA !== 32'hDEAD_BEEF) begin n_mismatched++; $display("[TB] FAIL b2b_hrdata: got %h want deadbeef", M0_HRDATA); end
        @(posedge CLK); #1;
    endtask

    task automatic test_hresp;
        do_reset();
        M1_HTRANS = 2'b10; M1_HADDR = 32'h20;
        @(posedge CLK); #1;
        M1_HTRANS = 2'b00;
        slave_err = 1'b1;
        @(negedge CLK);
        n_compared++; if (M1_HRESP !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hresp_owner: got %b want 1", M1_HRESP); end
        n_compared++; if (M0_HRESP !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hresp_other: got %b want 0", M0_HRESP); end
        @(posedge CLK); #1;
        @(negedge CLK);
        n_compared++; if (M1_HRESP !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hresp_no_dphase: got %b want 0", M1_HRESP); end
        @(posedge CLK); #1;
        slave_err = 1'b0;
    endtask

    task automatic test_reset_while_pending;
        do_reset();
        wait_states = 3;
        M0_HTRANS = 2'b10; M0_HADDR = 32'h10;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h14; M1_HWDATA = 32'h7777_0000;
        @(negedge CLK);
        n_compared++; if (S_HADDR !== 32'h10) begin n_mismatched++; $display("[TB] FAIL rp_first: got %h want 10", S_HADDR); end
        @(posedge CLK); #1;
        M0_HTRANS = 2'b00; M1_HTRANS = 2'b00;
        @(negedge CLK);
        n_compared++; if (M1_HREADY !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rp_m1_pend: got %b want 0", M1_HREADY); end
        #2 RES_N = 1'b0;
        #1;
        n_compared++; if (M1_HREADY !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rp_m1_release: got %b want 1", M1_HREADY); end
        n_compared++; if (M0_HREADY !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rp_m0_release: got %b want 1", M0_HREADY); end
        n_compared++; if (S_HWDATA !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rp_hwdata: got %h want 0", S_HWDATA); end
        @(posedge CLK); #1;
        RES_N = 1'b1;
        wait_states = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            n_compared++; if (S_HTRANS !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rp_no_issue%0d: got %b want 00", c, S_HTRANS); end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before end of tests");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_single_read();
        test_contention();
        test_arbitration_order();
        test_wait_states();
        test_back_to_back();
        test_hresp();
        test_reset_while_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ahb_ram_arbiter.md
AHB_RAM_ARBITER -- requirements
Module: ahb_ram_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = round-robin between masters and 0 = fixed priority with M0 highest.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports (name  direction  width  meaning):
- CLK  in  1  system clock.
- RES_N  in  1  asynchronous active-low reset.
- Mn_HTRANS  in  2  master n transfer type; n = 0 (instruction fetch), 1 (data/debug); same for every Mn_ port below.
- Mn_HWRITE  in  1  master n write.
- Mn_HSIZE  in  3  master n size.
- Mn_HADDR  in  32  master n address.
- Mn_HWDATA  in  32  master n write data.
- Mn_HREADY  out  1  master n ready.
- Mn_HRDATA  out  32  master n read data.
- Mn_HRESP  out  1  master n response.
- S_HSEL  out  1  slave select.
- S_HTRANS  out  2  slave transfer type.
- S_HWRITE  out  1  slave write.
- S_HSIZE  out  3  slave size.
- S_HBURST  out  3  slave burst, constant 3'b000.
- S_HPROT  out  4  slave protection, constant 4'b0011.
- S_HMASTLOCK  out  1  slave lock, constant 0.
- S_HADDR  out  32  slave address.
- S_HWDATA  out  32  slave write data.
- S_HREADY  out  1  slave HREADY in, equal to S_HREADYOUT.
- S_HREADYOUT  in  1  slave ready.
- S_HRDATA  in  32  slave read data.
- S_HRESP  in  1  slave response.

Function
REQ-004 Per-master state SHALL be IDLE, PEND or DATA; a one-entry pending buffer per master SHALL hold HADDR, HWRITE and HSIZE.
REQ-005 Live request n SHALL be Mn_HTRANS[1] & Mn_HREADY; SEQ is treated as NONSEQ; IDLE and BUSY SHALL be ignored.
REQ-006 Requester n SHALL be (state==PEND) | live n; arbitration SHALL occur only in cycles where S_HREADYOUT=1.
REQ-007 On a tie with ROUND_ROBIN=1, the master not granted last SHALL win; with ROUND_ROBIN=0, M0 SHALL win.
REQ-008 Grant SHALL drive S_HTRANS=2'b10 and S_HSEL=1, with address, write and size taken from the buffer if PEND, else from the live Mn_ inputs (zero added latency); winner -> DATA and dphase_owner=n.
REQ-009 With no grant or S_HREADYOUT=0, S_HTRANS SHALL be 2'b00 and S_HSEL SHALL be 0.
REQ-010 A live request that is not granted (it lost, or S_HREADYOUT=0) SHALL be captured into the buffer -> PEND.
REQ-011 Mn_HREADY SHALL = (state==IDLE) | (state==DATA & dphase_owner==n & S_HREADYOUT); it SHALL be 0 in PEND.
REQ-012 In a DATA completion cycle, a new live request from the same master SHALL be arbitrated in that same cycle -> DATA, PEND, or IDLE if no request.
REQ-013 S_HWDATA SHALL = Mn_HWDATA of dphase_owner.
REQ-014 Mn_HRDATA SHALL = S_HRDATA broadcast to both masters.
REQ-015 Mn_HRESP SHALL = S_HRESP when dphase_owner==n and a data phase is active, else 0.
REQ-016 The round-robin pointer SHALL update only on a grant.
REQ-017 At most one transfer SHALL be outstanding at the slave; both masters SHALL never be in DATA simultaneously.

Reset
REQ-018 RES_N=0 SHALL asynchronously force both masters to IDLE, clear buffers and the data-phase flag, and set last-granted=M1.
REQ-019 During reset, Mn_HREADY=1, S_HTRANS=2'b00, S_HSEL=0, and all data/response outputs SHALL be 0.
REQ-020 Reset mid-transfer SHALL discard pending requests; no slave transfer SHALL be issued in the first cycle after release unless a live request is present.

Verification
REQ-021 M0 read 0x100, M1 idle, zero-wait slave -> S_HADDR=0x100 the same cycle; M0_HREADY never 0; M0_HRDATA = RAM word next cycle.
REQ-022 After reset, M0 read 0x200 and M1 write 0x300 in the same cycle -> M0 granted; M1_HREADY=0 for 1 cycle; S_HADDR=0x300 next cycle; S_HWDATA=M1_HWDATA in the following cycle.
REQ-023 Both masters stream 4 reads each, ROUND_ROBIN=1 -> grant order 0,1,0,1,... With ROUND_ROBIN=0 -> all M0 reads first.
REQ-024 Slave with 3 wait states; M1 requests during the M0 data phase -> M1 in PEND; S_HTRANS=00 until S_HREADYOUT=1; M1 issued the same cycle S_HREADYOUT=1.
REQ-025 M1 writes 0xDEADBEEF to 0x40, then M0 reads 0x40 back-to-back -> M0_HRDATA=0xDEADBEEF.
REQ-026 RES_N pulsed low while M1 is in PEND -> M1_HREADY=1 immediately; no S_HTRANS=10 issued for the discarded request.
